// File: rtl/clk_div_monitor_pkg.sv
// Shared types and constants for the divided-clock monitor and its consumers.
// Holds FSM states, nominal divider periods and the error-counter helper.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Nominal rise-to-rise periods of the divider outputs, in clk cycles
  typedef enum logic [3:0] {
    DIV2_P = 4'd2,
    DIV4_P = 4'd4,
    DIV8_P = 4'd8
  } div_period_t;

  localparam int ERR_W = 8;

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_monitor_sync_edge_det.sv
// Brings the asynchronous divided clock into the clk domain and flags its edges.
// rise/fall are combinational from the last sync stage and its one-cycle delay.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      d_reg    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], div_in};
      d_reg    <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~d_reg;
  assign fall  = ~level & d_reg;

endmodule

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a /2, /4, /8 divided clock: measures period and high
// time, tracks lock against exp_period and flags mismatches and loss of signal.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_vld,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout,
  output logic [7:0]       err_cnt
);

  localparam int               MC_W       = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(DIV2_P);
  localparam logic [MC_W-1:0]  LOCK_C     = MC_W'(LOCK_COUNT);

  logic rise, fall, level_unused;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (clk),
    .rst   (rst),
    .div_in(div_in),
    .rise  (rise),
    .fall  (fall),
    .level (level_unused)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic             rise_stb_reg, fall_stb_reg;
  logic             period_vld_reg, period_vld_next;
  logic             locked_reg, locked_next;
  logic             mismatch_reg, mismatch_next;
  logic             timeout_reg, timeout_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;

  logic [CNT_W-1:0] meas;
  logic             good;

  // The cycle count since the last rise plus this cycle is the length being closed
  assign meas = cnt_reg + 1'b1;
  assign good = (meas == exp_period) && (high_time_reg == (exp_period >> 1));

  always_comb begin
    state_next      = state_reg;
    cnt_next        = rise ? '0 : ((cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1);
    match_cnt_next  = match_cnt_reg;
    period_next     = period_reg;
    high_time_next  = high_time_reg;
    period_vld_next = 1'b0;
    mismatch_next   = 1'b0;
    timeout_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rise && (exp_period >= MIN_PERIOD)) begin
          state_next     = ST_ACQ;
          match_cnt_next = '0;
        end
      end
      ST_ACQ, ST_LOCK: begin
        if (fall) begin
          high_time_next = meas;
        end
        if (rise) begin
          period_next     = meas;
          period_vld_next = 1'b1;
          if (good) begin
            if (state_reg == ST_ACQ) begin
              match_cnt_next = match_cnt_reg + 1'b1;
              if (match_cnt_reg == LOCK_C - 1'b1) begin
                state_next = ST_LOCK;
              end
            end
          end else begin
            mismatch_next  = 1'b1;
            match_cnt_next = '0;
            state_next     = ST_ACQ;
          end
        end else if (cnt_reg == TIMEOUT_C) begin
          // A rise in the same cycle wins, hence the else
          timeout_next   = 1'b1;
          match_cnt_next = '0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // locked follows the state one cycle late, except loss of signal drops it at once
    locked_next  = (state_reg == ST_LOCK) && !timeout_next;
    err_cnt_next = (mismatch_next || timeout_next) ? sat_inc_err(err_cnt_reg) : err_cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      match_cnt_reg  <= '0;
      period_reg     <= '0;
      high_time_reg  <= '0;
      rise_stb_reg   <= 1'b0;
      fall_stb_reg   <= 1'b0;
      period_vld_reg <= 1'b0;
      locked_reg     <= 1'b0;
      mismatch_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      match_cnt_reg  <= match_cnt_next;
      period_reg     <= period_next;
      high_time_reg  <= high_time_next;
      rise_stb_reg   <= rise;
      fall_stb_reg   <= fall;
      period_vld_reg <= period_vld_next;
      locked_reg     <= locked_next;
      mismatch_reg   <= mismatch_next;
      timeout_reg    <= timeout_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  assign rise_stb   = rise_stb_reg;
  assign fall_stb   = fall_stb_reg;
  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign period_vld = period_vld_reg;
  assign locked     = locked_reg;
  assign mismatch   = mismatch_reg;
  assign timeout    = timeout_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: the stimulus queues the expected
// measurement of each closed period, a monitor pops it on every period_vld.
module tb_clk_div_monitor;
  import clk_div_monitor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       div_in = 1'b0;
  logic [7:0] exp_period = 8'd4;
  logic       rise_stb, fall_stb, period_vld, locked, mismatch, timeout;
  logic [7:0] period, high_time, err_cnt;

  clk_div_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (8),
    .LOCK_COUNT (4),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .div_in    (div_in),
    .exp_period(exp_period),
    .rise_stb  (rise_stb),
    .fall_stb  (fall_stb),
    .period    (period),
    .high_time (high_time),
    .period_vld(period_vld),
    .locked    (locked),
    .mismatch  (mismatch),
    .timeout   (timeout),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] per;
    logic [7:0] hi;
    logic       bad;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rise_seen = 0;
  int   fall_seen = 0;
  int   to_seen = 0;
  int   prev_per = 0;
  int   prev_hi = 0;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Monitor: pops one expectation per period_vld and tracks strobes and timeouts
  initial begin : monitor
    exp_t e;
    bit   mm_prev = 1'b0;
    int   since_rise = 0;
    forever begin
      @(negedge clk);
      if (rise_stb) begin
        rise_seen++;
        since_rise = 0;
      end else begin
        since_rise++;
      end
      if (fall_stb) fall_seen++;
      if (period_vld) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_vld got period=%0d high=%0d required no period_vld", period, high_time);
        end else begin
          e = sb_q.pop_front();
          if ({period, high_time, mismatch} !== {e.per, e.hi, e.bad}) begin
            n_bad++;
            $display("FAIL vld got period=%0d high=%0d mismatch=%0d required period=%0d high=%0d mismatch=%0d",
                     period, high_time, mismatch, e.per, e.hi, e.bad);
          end else begin
            $display("ok   vld period=%0d high=%0d mismatch=%0d", period, high_time, mismatch);
          end
        end
      end else if (mismatch) begin
        n_cmp++;
        n_bad++;
        $display("FAIL mismatch_no_vld got mismatch=1 required 0");
      end
      if (mm_prev) check("locked_after_mismatch", int'(locked), 0);
      if (timeout) begin
        to_seen++;
        check("timeout_gap", since_rise, 256);
      end
      mm_prev = mismatch;
    end
  end

  task automatic push_prev();
    exp_t e;
    bit   ok_p;
    ok_p  = (prev_per == int'(exp_period)) && (prev_hi == int'(exp_period >> 1));
    e.per = prev_per[7:0];
    e.hi  = prev_hi[7:0];
    e.bad = !ok_p;
    sb_q.push_back(e);
  endtask

  // n periods of length per with hi cycles high; each rise closes the previous period
  task automatic run(input int n, input int per, input int hi);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        if (c == 0) begin
          if (prev_valid) push_prev();
          prev_per = per;
          prev_hi  = hi;
          if (exp_period >= 8'd2) prev_valid = 1'b1;
        end
        div_in = (c < hi);
      end
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(negedge clk);
      div_in = 1'b0;
    end
    prev_per += n;
  endtask

  task automatic check_zero(input string name);
    check(name, int'({rise_stb, fall_stb, period, high_time, period_vld, locked, mismatch, timeout, err_cnt}), 0);
  endtask

  task automatic do_reset(input logic [7:0] e);
    @(negedge clk);
    rst        = 1'b1;
    exp_period = e;
    @(negedge clk);
    check_zero("reset_outputs");
    rst        = 1'b0;
    prev_valid = 1'b0;
  endtask

  initial begin : stimulus
    int r0, f0, t0;

    // /4 lock acquisition
    do_reset(8'd4);
    run(4, int'(DIV4_P), 2);
    check("div4_locked_after_3", int'(locked), 0);
    run(2, int'(DIV4_P), 2);
    check("div4_locked_after_4", int'(locked), 1);
    check("div4_err", int'(err_cnt), 0);

    // /2 with strobe rate
    do_reset(8'd2);
    r0 = rise_seen; f0 = fall_seen;
    run(8, int'(DIV2_P), 1);
    hold_low(4);
    check("div2_locked", int'(locked), 1);
    check("div2_rises", rise_seen - r0, 8);
    check("div2_falls", fall_seen - f0, 8);

    // /8, then one stretched period, then relock
    do_reset(8'd8);
    r0 = rise_seen;
    run(6, int'(DIV8_P), 4);
    check("div8_locked", int'(locked), 1);
    check("div8_rises", rise_seen - r0, 6);
    run(1, 9, 4);
    run(5, int'(DIV8_P), 4);
    check("stretch_err", int'(err_cnt), 1);
    check("stretch_relocked", int'(locked), 1);

    // Loss of signal
    t0 = to_seen;
    hold_low(300);
    prev_valid = 1'b0;
    check("timeout_count", to_seen - t0, 1);
    check("timeout_err", int'(err_cnt), 2);
    check("timeout_locked", int'(locked), 0);
    run(1, int'(DIV8_P), 4);
    run(2, int'(DIV8_P), 4);
    hold_low(4);

    // Bad duty cycle saturates the error counter
    do_reset(8'd8);
    run(302, int'(DIV8_P), 3);
    hold_low(4);
    check("duty_err_sat", int'(err_cnt), 255);
    check("duty_never_locked", int'(locked), 0);

    // Reset while locked, then relock with the same timing
    do_reset(8'd4);
    run(6, int'(DIV4_P), 2);
    check("pre_reset_locked", int'(locked), 1);
    do_reset(8'd4);
    run(4, int'(DIV4_P), 2);
    check("relock_after_3", int'(locked), 0);
    run(2, int'(DIV4_P), 2);
    check("relock_after_4", int'(locked), 1);

    // exp_period below 2 keeps the monitor idle
    do_reset(8'd1);
    run(6, int'(DIV4_P), 2);
    hold_low(4);
    check("exp1_locked", int'(locked), 0);
    check("exp1_err", int'(err_cnt), 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
